// File: rtl/mimo_rx_sym_demapper_pkg.sv
// Shared constants for the MIMO receiver symbol demapper: FSM encodings, default
// frame parameters and the accumulator width rule.
package mimo_rx_sym_demapper_pkg;

    localparam logic [0:0]  ST_SEARCH         = 1'b0;
    localparam logic [0:0]  ST_PAYLOAD        = 1'b1;

    localparam int          SPS_DEF           = 4;
    localparam int          PRE_LEN_DEF       = 16;
    localparam logic [15:0] PREAMBLE_DEF      = 16'hE4B1;
    localparam int          PAYLOAD_BYTES_DEF = 16;

    // Summing SPS 8-bit signed samples needs log2(SPS) guard bits.
    function automatic int acc_width(input int sps);
        return 8 + $clog2(sps);
    endfunction

endpackage

// File: rtl/mimo_rx_int_dump.sv
// Integrate-and-dump over SPS samples per symbol followed by a sign slicer that
// produces the {bI,bQ} QPSK hard decision.
module mimo_rx_int_dump
    import mimo_rx_sym_demapper_pkg::*;
#(
    parameter int SPS = SPS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic signed [7:0] i_sample,
    input  logic signed [7:0] q_sample,
    output logic              sym_valid,
    output logic [1:0]        sym_bits
);

    localparam int             AW   = acc_width(SPS);
    localparam int             CW   = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(SPS - 1);

    logic [CW-1:0]        cnt_r;
    logic signed [AW-1:0] acc_i_r;
    logic signed [AW-1:0] acc_q_r;
    logic signed [AW-1:0] sum_i_s;
    logic signed [AW-1:0] sum_q_s;
    logic                 last_s;
    logic                 done_r;
    logic                 sign_i_r;
    logic                 sign_q_r;
    logic                 sym_valid_r;
    logic [1:0]           sym_bits_r;

    // Running sums including the sample currently presented.
    always_comb begin
        sum_i_s = acc_i_r + AW'(i_sample);
        sum_q_s = acc_q_r + AW'(q_sample);
        last_s  = (cnt_r == LAST);
    end

    // Accumulate, dump on the last sample, then slice one enabled cycle later.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r       <= {CW{1'b0}};
            acc_i_r     <= {AW{1'b0}};
            acc_q_r     <= {AW{1'b0}};
            done_r      <= 1'b0;
            sign_i_r    <= 1'b0;
            sign_q_r    <= 1'b0;
            sym_valid_r <= 1'b0;
            sym_bits_r  <= 2'b00;
        end else if (in_valid) begin
            done_r      <= last_s;
            sym_valid_r <= done_r;
            sym_bits_r  <= {sign_i_r, sign_q_r};
            if (last_s) begin
                cnt_r    <= {CW{1'b0}};
                acc_i_r  <= {AW{1'b0}};
                acc_q_r  <= {AW{1'b0}};
                sign_i_r <= sum_i_s[AW-1];
                sign_q_r <= sum_q_s[AW-1];
            end else begin
                cnt_r    <= cnt_r + CW'(1);
                acc_i_r  <= sum_i_s;
                acc_q_r  <= sum_q_s;
            end
        end
    end

    assign sym_valid = sym_valid_r;
    assign sym_bits  = sym_bits_r;

endmodule

// File: rtl/mimo_rx_sym_demapper.sv
// QPSK symbol demapper: preamble hunt, payload byte packing and frame framing
// pulses on top of the integrate-and-dump front end.
module mimo_rx_sym_demapper
    import mimo_rx_sym_demapper_pkg::*;
#(
    parameter int                 SPS           = SPS_DEF,
    parameter int                 PRE_LEN       = PRE_LEN_DEF,
    parameter logic [PRE_LEN-1:0] PREAMBLE      = PREAMBLE_DEF,
    parameter int                 PAYLOAD_BYTES = PAYLOAD_BYTES_DEF
) (
    input  logic              CLK_2,
    input  logic              RST,
    input  logic signed [7:0] I_TOTAL,
    input  logic signed [7:0] Q_TOTAL,
    input  logic              IN_VALID,
    output logic [7:0]        DATA_OUT,
    output logic              DATA_VALID,
    output logic              FRAME_START,
    output logic              FRAME_END,
    output logic              LOCKED
);

    localparam int             FW        = $clog2(PRE_LEN / 2 + 1);
    localparam logic [FW-1:0]  FILL_MAX  = FW'(PRE_LEN / 2);
    localparam int             BW        = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam logic [BW-1:0]  LAST_BYTE = BW'(PAYLOAD_BYTES - 1);

    logic               sym_valid_s;
    logic [1:0]         sym_bits_s;

    logic [0:0]         state_r;
    logic [PRE_LEN-1:0] sr_r;
    logic [FW-1:0]      fill_r;
    logic [1:0]         bit_cnt_r;
    logic [BW-1:0]      byte_cnt_r;
    logic [7:0]         byte_r;
    logic [7:0]         data_out_r;
    logic               data_valid_r;
    logic               frame_start_r;
    logic               frame_end_r;
    logic               locked_r;

    logic [PRE_LEN-1:0] sr_next_s;
    logic [FW-1:0]      fill_next_s;
    logic               match_s;
    logic [7:0]         byte_next_s;
    logic               byte_done_s;
    logic               last_byte_s;

    mimo_rx_int_dump #(
        .SPS (SPS)
    ) u_int_dump (
        .clk       (CLK_2),
        .rst_n     (RST),
        .in_valid  (IN_VALID),
        .i_sample  (I_TOTAL),
        .q_sample  (Q_TOTAL),
        .sym_valid (sym_valid_s),
        .sym_bits  (sym_bits_s)
    );

    // Next-state views of the preamble window and the byte being assembled.
    always_comb begin
        sr_next_s   = {sr_r[PRE_LEN-3:0], sym_bits_s};
        fill_next_s = (fill_r == FILL_MAX) ? fill_r : (fill_r + FW'(1));
        match_s     = (sr_next_s == PREAMBLE) && (fill_next_s == FILL_MAX);
        byte_next_s = {byte_r[5:0], sym_bits_s};
        byte_done_s = (bit_cnt_r == 2'd3);
        last_byte_s = (byte_cnt_r == LAST_BYTE);
    end

    // Framing FSM; a low IN_VALID freezes every register, pulses included.
    always_ff @(posedge CLK_2) begin
        if (!RST) begin
            state_r       <= ST_SEARCH;
            sr_r          <= {PRE_LEN{1'b0}};
            fill_r        <= {FW{1'b0}};
            bit_cnt_r     <= 2'd0;
            byte_cnt_r    <= {BW{1'b0}};
            byte_r        <= 8'h00;
            data_out_r    <= 8'h00;
            data_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_end_r   <= 1'b0;
            locked_r      <= 1'b0;
        end else if (IN_VALID) begin
            data_valid_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_end_r   <= 1'b0;
            if (sym_valid_s) begin
                case (state_r)
                    ST_SEARCH: begin
                        sr_r   <= sr_next_s;
                        fill_r <= fill_next_s;
                        if (match_s) begin
                            frame_start_r <= 1'b1;
                            bit_cnt_r     <= 2'd0;
                            byte_cnt_r    <= {BW{1'b0}};
                            state_r       <= ST_PAYLOAD;
                            locked_r      <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        byte_r    <= byte_next_s;
                        bit_cnt_r <= bit_cnt_r + 2'd1;
                        if (byte_done_s) begin
                            data_out_r   <= byte_next_s;
                            data_valid_r <= 1'b1;
                            byte_cnt_r   <= byte_cnt_r + BW'(1);
                            // Clearing the window keeps payload tail bits out of the next hunt.
                            if (last_byte_s) begin
                                frame_end_r <= 1'b1;
                                sr_r        <= {PRE_LEN{1'b0}};
                                fill_r      <= {FW{1'b0}};
                                state_r     <= ST_SEARCH;
                                locked_r    <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state_r  <= ST_SEARCH;
                        locked_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DATA_OUT    = data_out_r;
    assign DATA_VALID  = data_valid_r;
    assign FRAME_START = frame_start_r;
    assign FRAME_END   = frame_end_r;
    assign LOCKED      = locked_r;

endmodule

// File: tb/tb_mimo_rx_sym_demapper.sv
// Scoreboard bench for mimo_rx_sym_demapper: stimulus pushes expected bytes,
// a negedge monitor pops and compares whenever DATA_VALID is presented.
module tb_mimo_rx_sym_demapper;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] i_tot;
    logic signed [7:0] q_tot;
    logic              in_valid;
    logic [7:0]        data_out;
    logic              data_valid;
    logic              frame_start;
    logic              frame_end;
    logic              locked;

    exp_t       exp_q[$];
    int         n_checks    = 0;
    int         n_fail      = 0;
    int         starts_seen = 0;
    int         starts_exp  = 0;
    bit         rand_gaps   = 1'b0;
    logic       adv_r       = 1'b0;
    logic       rst_edge_r  = 1'b0;
    logic [11:0] prev_out   = 12'h000;
    logic [7:0] payload [16];

    always #5 clk = ~clk;

    mimo_rx_sym_demapper dut (
        .CLK_2       (clk),
        .RST         (rst),
        .I_TOTAL     (i_tot),
        .Q_TOTAL     (q_tot),
        .IN_VALID    (in_valid),
        .DATA_OUT    (data_out),
        .DATA_VALID  (data_valid),
        .FRAME_START (frame_start),
        .FRAME_END   (frame_end),
        .LOCKED      (locked)
    );

    always @(posedge clk) begin
        adv_r      <= in_valid || !rst;
        rst_edge_r <= !rst;
    end

    // Monitor: reset, freeze and scoreboard checks half a cycle after each edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_edge_r) begin
            n_checks++;
            if ({data_out, data_valid, frame_start, frame_end, locked} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 000",
                         {data_out, data_valid, frame_start, frame_end, locked});
            end
        end else if (!adv_r) begin
            n_checks++;
            if ({data_out, data_valid, frame_start, frame_end, locked} !== prev_out) begin
                n_fail++;
                $display("FAIL frozen_outputs: got %h expected %h",
                         {data_out, data_valid, frame_start, frame_end, locked}, prev_out);
            end
        end else begin
            if (frame_start === 1'b1) begin
                starts_seen++;
                n_checks++;
                if (locked !== 1'b1 || starts_seen > starts_exp) begin
                    n_fail++;
                    $display("FAIL frame_start: locked %b starts %0d expected at most %0d",
                             locked, starts_seen, starts_exp);
                end
            end
            if (data_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %h with nothing expected", data_out);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out !== e.data || frame_end !== e.last || locked !== !e.last) begin
                        n_fail++;
                        $display("FAIL byte: got data %h end %b locked %b expected data %h end %b locked %b",
                                 data_out, frame_end, locked, e.data, e.last, !e.last);
                    end
                end
            end else if (frame_end !== 1'b0 || data_valid !== 1'b0) begin
                n_checks++;
                n_fail++;
                $display("FAIL stray_frame_end: got end %b valid %b expected 0 0", frame_end, data_valid);
            end
        end
        prev_out <= {data_out, data_valid, frame_start, frame_end, locked};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic signed [7:0] i, input logic signed [7:0] q);
        if (rand_gaps) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                i_tot    = 8'($urandom);
                q_tot    = 8'($urandom);
                tick();
            end
        end
        in_valid = 1'b1;
        i_tot    = i;
        q_tot    = q;
        tick();
    endtask

    task automatic sym(input logic bi, input logic bq);
        for (int k = 0; k < 4; k++)
            put(bi ? -8'sd20 : 8'sd20, bq ? -8'sd20 : 8'sd20);
    endtask

    task automatic raw_sym(input logic [31:0] iv, input logic [31:0] qv);
        for (int k = 0; k < 4; k++)
            put(iv[8*(3-k) +: 8], qv[8*(3-k) +: 8]);
    endtask

    task automatic expect_byte(input logic [7:0] b, input logic last);
        exp_t e;
        e.data = b;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        expect_byte(b, last);
        for (int s = 0; s < 4; s++)
            sym(b[7-2*s], b[6-2*s]);
    endtask

    task automatic send_preamble();
        logic [15:0] p;
        p = 16'hE4B1;
        starts_exp++;
        for (int s = 0; s < 8; s++)
            sym(p[15-2*s], p[14-2*s]);
    endtask

    task automatic send_frame();
        send_preamble();
        for (int b = 0; b < 16; b++)
            send_byte(payload[b], b == 15);
    endtask

    task automatic flush_idle();
        sym(1'b0, 1'b0);
        sym(1'b0, 1'b0);
        in_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic check_quiet(input string name);
        n_checks++;
        if (exp_q.size() != 0 || starts_seen != starts_exp) begin
            n_fail++;
            $display("FAIL %s: pending %0d starts %0d expected pending 0 starts %0d",
                     name, exp_q.size(), starts_seen, starts_exp);
        end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b1;
        i_tot    = 8'sd0;
        q_tot    = 8'sd0;

        // Test 1: reset held with live random samples.
        for (int c = 0; c < 3; c++) begin
            i_tot = 8'($urandom);
            q_tot = 8'($urandom);
            tick();
        end
        rst = 1'b1;

        // Test 2: preamble then bytes 0x00..0x0F.
        for (int b = 0; b < 16; b++) payload[b] = 8'(b);
        send_frame();
        flush_idle();
        check_quiet("frame_basic");

        // Test 3: slicer edge sums, packed as symbols 00,11,01,10 -> 0x36.
        send_preamble();
        send_byte(8'hA5, 1'b0);
        expect_byte(8'h36, 1'b0);
        raw_sym(32'h1E_FB_F6_FE, 32'h01_FF_02_FE);
        raw_sym(32'h80_80_80_80, 32'h80_80_80_80);
        raw_sym(32'h01_FF_02_FE, 32'h80_80_80_80);
        raw_sym(32'h80_80_80_80, 32'h1E_FB_F6_FE);
        for (int b = 2; b < 16; b++) send_byte(8'(8'h40 + b), b == 15);
        flush_idle();
        check_quiet("slicer_frame");

        // Test 4: test 2 stimulus with IN_VALID randomly low.
        rand_gaps = 1'b1;
        for (int b = 0; b < 16; b++) payload[b] = 8'(b);
        send_frame();
        flush_idle();
        rand_gaps = 1'b0;
        check_quiet("gapped_frame");

        // Test 5: preamble bytes inside payload, then a back-to-back frame.
        for (int b = 0; b < 16; b++) payload[b] = 8'(8'h11 * (b % 4));
        payload[3] = 8'hE4;
        payload[4] = 8'hB1;
        payload[8] = 8'hE4;
        payload[9] = 8'hB1;
        send_frame();
        for (int b = 0; b < 16; b++) payload[b] = 8'(8'hF0 - b);
        send_frame();
        flush_idle();
        check_quiet("back_to_back");

        // Test 6: reset after 5 payload bytes aborts the frame.
        send_preamble();
        for (int b = 0; b < 5; b++) send_byte(8'(8'hC0 + b), 1'b0);
        sym(1'b1, 1'b0);
        sym(1'b0, 1'b1);
        in_valid = 1'b1;
        rst      = 1'b0;
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (3) tick();
        check_quiet("reset_abort");
        for (int b = 0; b < 16; b++) payload[b] = 8'(8'h5A ^ b);
        send_frame();
        flush_idle();
        check_quiet("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
